alu_exec_unit: RTL and testbench



---
 rtl/alu_exec_unit_if.sv | 29 ++
 rtl/alu_exec_unit.sv | 128 ++++++++++++
 tb/tb_alu_exec_unit.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_if.sv
// Operand/result handshake bundle between register-read, the execution unit and writeback.
interface alu_exec_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             illegal;
  logic [15:0]      op_count;

  // Upstream producer / downstream consumer side
  modport master (
    output in_valid, alu_control, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, overflow, illegal, op_count
  );

  // Execution unit side
  modport slave (
    input  in_valid, alu_control, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, overflow, illegal, op_count
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Two-stage pipelined ALU: S1 captures operands, S2 holds the computed result and flags.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic       clk,
  input logic       rst_n,
  alu_exec_if.slave bus
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLT = 4'b0101;
  localparam int unsigned CNT_W = 16;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [3:0]       s1_ctrl;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_result;
  logic             s2_zero;
  logic             s2_overflow;
  logic             s2_illegal;
  logic [CNT_W-1:0] count;

  logic             s2_free;
  logic             s1_adv;
  logic             in_fire;
  logic             out_fire;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             slt_bit;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_ill;

  // Handshake and advance control; out_ready is the only combinational input to in_ready
  assign s2_free  = !s2_valid || bus.out_ready;
  assign s1_adv   = s1_valid && s2_free;
  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = s2_valid && bus.out_ready;

  assign bus.in_ready  = !s1_valid || s2_free;
  assign bus.out_valid = s2_valid;
  assign bus.result    = s2_result;
  assign bus.zero      = s2_zero;
  assign bus.overflow  = s2_overflow;
  assign bus.illegal   = s2_illegal;
  assign bus.op_count  = count;

  assign sum     = s1_a + s1_b;
  assign diff    = s1_a - s1_b;
  // Signed compare directly, so the answer is correct even when a-b would overflow
  assign slt_bit = $signed(s1_a) < $signed(s1_b);

  // Operation decode and flag generation for the bundle held in S1
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (s1_ctrl)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (diff[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_AND:  alu_res = s1_a & s1_b;
      OP_OR:   alu_res = s1_a | s1_b;
      OP_XOR:  alu_res = s1_a ^ s1_b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
      default: alu_ill = 1'b1;
    endcase
  end

  // S1: capture on input handshake, empty when moved on to S2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_ctrl  <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_a     <= bus.src_a;
      s1_b     <= bus.src_b;
      s1_ctrl  <= bus.alu_control;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // S2: result register, held stable while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid    <= 1'b0;
      s2_result   <= '0;
      s2_zero     <= 1'b0;
      s2_overflow <= 1'b0;
      s2_illegal  <= 1'b0;
    end else if (s1_adv) begin
      s2_valid    <= 1'b1;
      s2_result   <= alu_res;
      s2_zero     <= (alu_res == '0);
      s2_overflow <= alu_ovf;
      s2_illegal  <= alu_ill;
    end else if (out_fire) begin
      s2_valid    <= 1'b0;
    end
  end

  // Completed output handshakes, wrapping modulo 2^16
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (out_fire) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit.
module tb_alu_exec_unit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   exp_count;

  alu_exec_if #(.WIDTH(32)) bus ();

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.alu_control = 4'd0;
    bus.src_a = 32'd0;
    bus.src_b = 32'd0;
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== 32'd0 || bus.zero !== 1'b0 ||
        bus.overflow !== 1'b0 || bus.illegal !== 1'b0 || bus.op_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b r=%h z=%b o=%b i=%b c=%h, expected all zero",
               bus.out_valid, bus.result, bus.zero, bus.overflow, bus.illegal, bus.op_count);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    exp_count = 0;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  c [6];
    logic [31:0] a [6];
    logic [31:0] b [6];
    logic [31:0] r [6];
    logic        z [6];
    c = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    a = '{32'd5, 32'd3, 32'h0000F0F0, 32'h0000F0F0, 32'h0000F0F0, 32'hFFFFFFFF};
    b = '{32'd7, 32'd3, 32'h0000FF00, 32'h0000FF00, 32'h0000FF00, 32'd1};
    r = '{32'd12, 32'd0, 32'h0000F000, 32'h0000FFF0, 32'h00000FF0, 32'd1};
    z = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin
        bus.in_valid = 1'b1;
        bus.alu_control = c[i];
        bus.src_a = a[i];
        bus.src_b = b[i];
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (i < 6) begin
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, bus.in_ready);
        end
      end
      if (i == 1) begin
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_latency: out_valid got %b expected 0 one edge after accept", bus.out_valid);
        end
      end
      if (i >= 2) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.result !== r[i-2] || bus.zero !== z[i-2] ||
            bus.overflow !== 1'b0 || bus.illegal !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_result[%0d]: got v=%b r=%h z=%b o=%b i=%b expected v=1 r=%h z=%b o=0 i=0",
                   i-2, bus.out_valid, bus.result, bus.zero, bus.overflow, bus.illegal, r[i-2], z[i-2]);
        end
        exp_count++;
      end
      tick();
    end
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.op_count !== 16'(exp_count)) begin
      n_fail++;
      $display("FAIL b2b_count: got v=%b count=%0d expected v=0 count=%0d",
               bus.out_valid, bus.op_count, exp_count);
    end
  endtask

  task automatic test_overflow();
    logic [3:0]  c [3];
    logic [31:0] a [3];
    logic [31:0] b [3];
    logic [31:0] r [3];
    logic        o [3];
    c = '{4'd0, 4'd1, 4'd5};
    a = '{32'h7FFFFFFF, 32'h80000000, 32'h80000000};
    b = '{32'd1, 32'd1, 32'd1};
    r = '{32'h80000000, 32'h7FFFFFFF, 32'd1};
    o = '{1'b1, 1'b1, 1'b0};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i < 3);
      if (i < 3) begin
        bus.alu_control = c[i];
        bus.src_a = a[i];
        bus.src_b = b[i];
      end
      #1;
      if (i >= 2) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.result !== r[i-2] || bus.overflow !== o[i-2] ||
            bus.zero !== 1'b0 || bus.illegal !== 1'b0) begin
          n_fail++;
          $display("FAIL ovf_result[%0d]: got v=%b r=%h o=%b z=%b i=%b expected v=1 r=%h o=%b z=0 i=0",
                   i-2, bus.out_valid, bus.result, bus.overflow, bus.zero, bus.illegal, r[i-2], o[i-2]);
        end
        exp_count++;
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.alu_control = 4'b0111;
    bus.src_a = 32'd9;
    bus.src_b = 32'd4;
    tick();
    bus.alu_control = 4'b0000;
    bus.src_a = 32'd2;
    bus.src_b = 32'd3;
    tick();
    bus.in_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd0 || bus.illegal !== 1'b1 ||
        bus.zero !== 1'b1 || bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_op: got v=%b r=%h i=%b z=%b o=%b expected v=1 r=0 i=1 z=1 o=0",
               bus.out_valid, bus.result, bus.illegal, bus.zero, bus.overflow);
    end
    exp_count++;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd5 || bus.illegal !== 1'b0 || bus.zero !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_clear: got v=%b r=%h i=%b z=%b expected v=1 r=5 i=0 z=0",
               bus.out_valid, bus.result, bus.illegal, bus.zero);
    end
    exp_count++;
    tick();
    n_checks++;
    if (bus.op_count !== 16'(exp_count)) begin
      n_fail++;
      $display("FAIL illegal_count: got %0d expected %0d", bus.op_count, exp_count);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.alu_control = 4'd0;
    bus.src_a = 32'd1;
    bus.src_b = 32'd1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_accept0: in_ready got %b expected 1", bus.in_ready);
    end
    tick();
    bus.alu_control = 4'd1;
    bus.src_a = 32'd10;
    bus.src_b = 32'd4;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_accept1: in_ready got %b expected 1", bus.in_ready);
    end
    tick();
    bus.alu_control = 4'd4;
    bus.src_a = 32'h000000FF;
    bus.src_b = 32'h0000000F;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.result !== 32'd2) begin
        n_fail++;
        $display("FAIL bp_stall[%0d]: got rdy=%b v=%b r=%h expected rdy=0 v=1 r=2",
                 k, bus.in_ready, bus.out_valid, bus.result);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_ready: in_ready got %b expected 1", bus.in_ready);
    end
    exp_count++;
    tick();
    bus.in_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd6) begin
      n_fail++;
      $display("FAIL bp_drain1: got v=%b r=%h expected v=1 r=6", bus.out_valid, bus.result);
    end
    exp_count++;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'h000000F0) begin
      n_fail++;
      $display("FAIL bp_drain2: got v=%b r=%h expected v=1 r=f0", bus.out_valid, bus.result);
    end
    exp_count++;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.op_count !== 16'(exp_count)) begin
      n_fail++;
      $display("FAIL bp_count: got v=%b count=%0d expected v=0 count=%0d",
               bus.out_valid, bus.op_count, exp_count);
    end
  endtask

  task automatic test_reset_midflight();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.alu_control = 4'd0;
    bus.src_a = 32'd100;
    bus.src_b = 32'd1;
    tick();
    bus.src_a = 32'd200;
    tick();
    bus.in_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre: out_valid got %b expected 1", bus.out_valid);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.op_count !== 16'd0 || bus.result !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_async: got v=%b c=%0d r=%h expected v=0 c=0 r=0",
               bus.out_valid, bus.op_count, bus.result);
    end
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    exp_count = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.op_count !== 16'd0) begin
        n_fail++;
        $display("FAIL rst_stale[%0d]: got v=%b c=%0d expected v=0 c=0", k, bus.out_valid, bus.op_count);
      end
    end
    bus.in_valid = 1'b1;
    bus.alu_control = 4'd3;
    bus.src_a = 32'h0000000A;
    bus.src_b = 32'h00000005;
    tick();
    bus.in_valid = 1'b0;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'h0000000F) begin
      n_fail++;
      $display("FAIL rst_next: got v=%b r=%h expected v=1 r=f", bus.out_valid, bus.result);
    end
    exp_count++;
    tick();
    n_checks++;
    if (bus.op_count !== 16'(exp_count)) begin
      n_fail++;
      $display("FAIL rst_next_count: got %0d expected %0d", bus.op_count, exp_count);
    end
  endtask

  task automatic test_count_wrap();
    int n;
    n = 65535 - exp_count;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.alu_control = 4'd0;
    bus.src_a = 32'd0;
    bus.src_b = 32'd0;
    for (int k = 0; k < n; k++) tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    n_checks++;
    if (bus.op_count !== 16'hFFFF || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_max: got c=%h v=%b expected c=ffff v=0", bus.op_count, bus.out_valid);
    end
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    n_checks++;
    if (bus.op_count !== 16'hFFFF || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_hold: got c=%h v=%b expected c=ffff v=1", bus.op_count, bus.out_valid);
    end
    tick();
    n_checks++;
    if (bus.op_count !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap_zero: got c=%h expected 0000", bus.op_count);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    exp_count = 0;
    test_reset();
    test_back_to_back();
    test_overflow();
    test_illegal();
    test_backpressure();
    test_reset_midflight();
    test_count_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
